// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Bits needed to count 0..w-1; a 2-bit word still needs a 1-bit counter.
  function automatic int cnt_width(int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Mod-WIDTH bit position counter; wrap flags the cycle that completes a word.
module bit_counter
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // A realign on the last bit position restarts the word instead of completing it.
  assign wrap = inc && !clr && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Packs an MSB-first serial stream into WIDTH-bit words and hands them out
// through a single-entry valid/ready buffer with a sticky overflow flag.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clr_overflow
);

  // Only WIDTH-1 bits need storing: the final bit arrives live on bit_in.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic             wrap;

  buf_state_t state, state_nxt;
  logic       handshake;
  logic       load;
  logic       drop;

  assign next_word = {shreg, bit_in};

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (bit_valid),
    .clr   (sync),
    .wrap  (wrap)
  );

  // Stale bits left behind by sync are shifted out before the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (bit_valid) begin
      shreg <= next_word[WIDTH-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (wrap) state_nxt = BUF_FULL;
      BUF_FULL:  if (word_ready && !wrap) state_nxt = BUF_EMPTY;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  always_comb begin
    word_valid = (state == BUF_FULL);
    handshake  = word_valid && word_ready;
    load       = wrap && (!word_valid || handshake);
    drop       = wrap && word_valid && !word_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_out <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) word_out <= next_word;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule
